// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and helpers for the switch_debounce block:
//               per-bit FSM state encoding, stability-counter width helper
//               and glitch-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Width of the saturating rejected-bounce counter
    localparam int GLITCH_W = 8;

    // Per-bit qualification state
    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } db_state_t;

    // Stability counter width: must hold DEBOUNCE_CYCLES-1, never below 1 bit
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : One switch bit: two-flop synchronizer, stability counter,
//               STABLE/COUNT qualification FSM and registered rise/fall
//               strobes. o_abort flags a COUNT->STABLE bounce rejection.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sw,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall,
    output logic o_abort
);

    localparam int            CW         = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    logic          r_meta;
    logic          r_sync;
    db_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_clean;
    logic          r_rise;
    logic          r_fall;

    // Two-flop synchronizer for the asynchronous raw switch level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_sw;
            r_sync <= r_meta;
        end
    end

    // Qualification FSM: a new level is accepted only after holding for
    // DEBOUNCE_CYCLES clocks; strobes default low so they last one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE: begin
                    if (r_sync != r_clean) begin
                        r_state <= COUNT;
                        r_cnt   <= C_CNT_ONE;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                COUNT: begin
                    if (r_sync == r_clean) begin
                        // Bounced back before qualifying: drop silently
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_clean <= r_sync;
                        r_rise  <= r_sync;
                        r_fall  <= ~r_sync;
                        r_cnt   <= '0;
                        r_state <= STABLE;
                    end else begin
                        r_cnt   <= r_cnt + C_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= STABLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    // High in the cycle whose clock edge performs a bounce abort
    assign o_abort = (r_state == COUNT) && (r_sync == r_clean);

endmodule : debounce_bit
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : Conditions NUM_SW raw slide-switch inputs into clean
//               synchronous levels plus one-cycle rise/fall strobes.
//               Optional macro SWITCH_DEBOUNCE_GLITCH_CNT_EN adds an 8-bit
//               saturating GLITCH_CNT of rejected bounces across all bits.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce
    import debounce_pkg::*;
#(
    parameter int NUM_SW          = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                CPU_RESETN,
    input  logic [NUM_SW-1:0]   SW,
    output logic [NUM_SW-1:0]   SW_CLEAN,
    output logic [NUM_SW-1:0]   SW_RISE,
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    output logic [NUM_SW-1:0]   SW_FALL,
    output logic [GLITCH_W-1:0] GLITCH_CNT
`else
    output logic [NUM_SW-1:0]   SW_FALL
`endif
);

    logic [NUM_SW-1:0] w_abort;

    // One independent debouncer per switch bit
    generate
        for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_bit
            debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_bit (
                .clk     (clk),
                .rst_n   (CPU_RESETN),
                .i_sw    (SW[gi]),
                .o_clean (SW_CLEAN[gi]),
                .o_rise  (SW_RISE[gi]),
                .o_fall  (SW_FALL[gi]),
                .o_abort (w_abort[gi])
            );
        end
    endgenerate

`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    logic [4:0]          w_abort_cnt;
    logic [GLITCH_W:0]   w_glitch_sum;
    logic [GLITCH_W-1:0] r_glitch;

    // Population count of bits aborting this cycle
    always_comb begin
        w_abort_cnt = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            w_abort_cnt = w_abort_cnt + {4'b0, w_abort[i]};
        end
    end

    assign w_glitch_sum = {1'b0, r_glitch} + (GLITCH_W + 1)'(w_abort_cnt);

    // Saturating accumulation of rejected bounces
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_glitch <= '0;
        end else if (w_glitch_sum[GLITCH_W]) begin
            r_glitch <= '1;
        end else begin
            r_glitch <= w_glitch_sum[GLITCH_W-1:0];
        end
    end

    assign GLITCH_CNT = r_glitch;
`else
    logic w_unused_abort;
    assign w_unused_abort = ^w_abort;
`endif

endmodule : switch_debounce
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debounce
// Description : Self-checking bench for switch_debounce, DEBOUNCE_CYCLES=8,
//               NUM_SW=2. Inputs change and outputs are sampled on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debounce;

    localparam int C_NUM_SW = 2;
    localparam int C_DB     = 8;

    logic                clk;
    logic                CPU_RESETN;
    logic [C_NUM_SW-1:0] SW;
    logic [C_NUM_SW-1:0] SW_CLEAN;
    logic [C_NUM_SW-1:0] SW_RISE;
    logic [C_NUM_SW-1:0] SW_FALL;
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0]          GLITCH_CNT;
`endif

    switch_debounce #(
        .NUM_SW          (C_NUM_SW),
        .DEBOUNCE_CYCLES (C_DB)
    ) dut (
        .clk        (clk),
        .CPU_RESETN (CPU_RESETN),
        .SW         (SW),
        .SW_CLEAN   (SW_CLEAN),
        .SW_RISE    (SW_RISE),
`ifdef SWITCH_DEBOUNCE_GLITCH_CNT_EN
        .SW_FALL    (SW_FALL),
        .GLITCH_CNT (GLITCH_CNT)
`else
        .SW_FALL    (SW_FALL)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] sw;
        int         n;
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;

    vec_t vecs[$];
    int   n_total = 0;
    int   n_pass  = 0;

    function automatic void add(input string nm, input logic [1:0] sw, input int n,
                                input logic [1:0] cl, input logic [1:0] ri,
                                input logic [1:0] fa);
        vec_t v;
        v.name = nm; v.sw = sw; v.n = n; v.clean = cl; v.rise = ri; v.fall = fa;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [1:0] cl, input logic [1:0] ri,
                         input logic [1:0] fa);
        n_total++;
        if (SW_CLEAN === cl && SW_RISE === ri && SW_FALL === fa) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got clean=%b rise=%b fall=%b, expected clean=%b rise=%b fall=%b",
                     nm, SW_CLEAN, SW_RISE, SW_FALL, cl, ri, fa);
        end
    endtask

    // After a reset release with SW=11: quiet for 9 cycles, clean/rise at 10
    task automatic check_release(input string nm);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i < 10)       check({nm, "_quiet"}, 2'b00, 2'b00, 2'b00);
            else if (i == 10) check({nm, "_rise"},  2'b11, 2'b11, 2'b00);
            else              check({nm, "_after"}, 2'b11, 2'b00, 2'b00);
        end
    endtask

    initial begin
        // Step table, starting from clean=11 with SW=11
        add("to10_wait",    2'b10, 9, 2'b11, 2'b00, 2'b00);
        add("to10_fall",    2'b10, 1, 2'b10, 2'b00, 2'b01);
        add("to10_single",  2'b10, 1, 2'b10, 2'b00, 2'b00);
        add("step_r_wait",  2'b11, 9, 2'b10, 2'b00, 2'b00);
        add("step_r",       2'b11, 1, 2'b11, 2'b01, 2'b00);
        add("step_r_one",   2'b11, 1, 2'b11, 2'b00, 2'b00);
        add("step_f_wait",  2'b10, 9, 2'b11, 2'b00, 2'b00);
        add("step_f",       2'b10, 1, 2'b10, 2'b00, 2'b01);
        add("step_f_one",   2'b10, 1, 2'b10, 2'b00, 2'b00);
        add("b1_f_wait",    2'b00, 9, 2'b10, 2'b00, 2'b00);
        add("b1_f",         2'b00, 1, 2'b00, 2'b00, 2'b10);
        add("b1_f_one",     2'b00, 1, 2'b00, 2'b00, 2'b00);
        // Bounce: 3-cycle pulses on bit 1, then held high
        add("bnc_hi1",      2'b10, 3, 2'b00, 2'b00, 2'b00);
        add("bnc_lo1",      2'b00, 3, 2'b00, 2'b00, 2'b00);
        add("bnc_hi2",      2'b10, 3, 2'b00, 2'b00, 2'b00);
        add("bnc_lo2",      2'b00, 3, 2'b00, 2'b00, 2'b00);
        add("bnc_hold",     2'b10, 9, 2'b00, 2'b00, 2'b00);
        add("bnc_rise",     2'b10, 1, 2'b10, 2'b10, 2'b00);
        add("bnc_one",      2'b10, 1, 2'b10, 2'b00, 2'b00);
        add("bnc_f_wait",   2'b00, 9, 2'b10, 2'b00, 2'b00);
        add("bnc_f",        2'b00, 1, 2'b00, 2'b00, 2'b10);
        add("bnc_f_one",    2'b00, 1, 2'b00, 2'b00, 2'b00);
        // Short pulse: 7 cycles rejected, 8 cycles accepted
        add("p7_hi",        2'b01, 7, 2'b00, 2'b00, 2'b00);
        add("p7_lo_a",      2'b00, 3, 2'b00, 2'b00, 2'b00);
        add("p7_lo_b",      2'b00, 9, 2'b00, 2'b00, 2'b00);
        add("p8_hi",        2'b01, 8, 2'b00, 2'b00, 2'b00);
        add("p8_pre",       2'b00, 1, 2'b00, 2'b00, 2'b00);
        add("p8_rise",      2'b00, 1, 2'b01, 2'b01, 2'b00);
        add("p8_hold_a",    2'b00, 1, 2'b01, 2'b00, 2'b00);
        add("p8_hold_b",    2'b00, 6, 2'b01, 2'b00, 2'b00);
        add("p8_fall",      2'b00, 1, 2'b00, 2'b00, 2'b01);
        add("p8_fall_one",  2'b00, 1, 2'b00, 2'b00, 2'b00);
        // Independent bits: simultaneous rise, then staggered fall by 3
        add("sim_wait",     2'b11, 9, 2'b00, 2'b00, 2'b00);
        add("sim_rise",     2'b11, 1, 2'b11, 2'b11, 2'b00);
        add("sim_one",      2'b11, 1, 2'b11, 2'b00, 2'b00);
        add("stg_b1",       2'b01, 3, 2'b11, 2'b00, 2'b00);
        add("stg_wait",     2'b00, 6, 2'b11, 2'b00, 2'b00);
        add("stg_f1",       2'b00, 1, 2'b01, 2'b00, 2'b10);
        add("stg_gap_a",    2'b00, 1, 2'b01, 2'b00, 2'b00);
        add("stg_gap_b",    2'b00, 1, 2'b01, 2'b00, 2'b00);
        add("stg_f0",       2'b00, 1, 2'b00, 2'b00, 2'b01);
        add("stg_f0_one",   2'b00, 1, 2'b00, 2'b00, 2'b00);

        // Reset held with switches high: outputs stay clear
        CPU_RESETN = 1'b0;
        SW         = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_hold", 2'b00, 2'b00, 2'b00);
        CPU_RESETN = 1'b1;
        check_release("rst_rel");

        // Directed step table
        foreach (vecs[k]) begin
            SW = vecs[k].sw;
            repeat (vecs[k].n) @(negedge clk);
            check(vecs[k].name, vecs[k].clean, vecs[k].rise, vecs[k].fall);
        end

        // Reset in the middle of a qualification count
        SW = 2'b10;
        repeat (10) @(negedge clk);
        check("mid_pre_rise", 2'b10, 2'b10, 2'b00);
        SW = 2'b11;
        repeat (7) @(negedge clk);
        check("mid_counting", 2'b10, 2'b00, 2'b00);
        #2 CPU_RESETN = 1'b0;
        #1 check("mid_async_clear", 2'b00, 2'b00, 2'b00);
        repeat (2) @(negedge clk);
        check("mid_held", 2'b00, 2'b00, 2'b00);
        CPU_RESETN = 1'b1;
        check_release("mid_rel");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_switch_debounce
`default_nettype wire
